// File: rtl/if_id_buffer.sv
// Fetch-to-decode FIFO of {PC, instruction} pairs with full-driven stall and redirect flush.
// Optional same-cycle pass-through when empty is enabled by defining IF_ID_BYPASS_EN.
module if_id_buffer #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    input  logic [W-1:0]             IN_PC,
    input  logic [W-1:0]             IN_INSTR,
    output logic                     STALL,
    output logic                     OUT_VALID,
    output logic [W-1:0]             OUT_PC,
    output logic [W-1:0]             OUT_INSTR,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_pc    [DEPTH];
    logic [W-1:0]  mem_instr [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign STALL = full;
    assign COUNT = count_reg;

    // rd_en only ever retires a stored entry; a bypassed pair never touches the pointers.
    assign rd_en = OUT_READY & ~empty & ~FLUSH;

`ifdef IF_ID_BYPASS_EN
    logic bypass;
    assign bypass    = empty & IN_VALID & ~FLUSH;
    assign wr_en     = IN_VALID & ~full & ~FLUSH & ~(bypass & OUT_READY);
    assign OUT_VALID = ~empty | bypass;
    assign OUT_PC    = bypass ? IN_PC    : (empty ? '0 : mem_pc[rd_ptr_reg]);
    assign OUT_INSTR = bypass ? IN_INSTR : (empty ? '0 : mem_instr[rd_ptr_reg]);
`else
    assign wr_en     = IN_VALID & ~full & ~FLUSH;
    assign OUT_VALID = ~empty;
    assign OUT_PC    = empty ? '0 : mem_pc[rd_ptr_reg];
    assign OUT_INSTR = empty ? '0 : mem_instr[rd_ptr_reg];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (FLUSH) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_en)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entries live in flops so reset can clear every one of them.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    mem_pc[gi]    <= '0;
                    mem_instr[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                    mem_pc[gi]    <= IN_PC;
                    mem_instr[gi] <= IN_INSTR;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed test-plan sequences then random traffic vs a queue model.
// Build with IF_ID_BYPASS_EN defined to check the same-cycle pass-through variant.
module tb_if_id_buffer;

    localparam int W     = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          FLUSH = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [W-1:0]  IN_PC = '0;
    logic [W-1:0]  IN_INSTR = '0;
    logic          OUT_READY = 1'b0;
    logic          STALL;
    logic          OUT_VALID;
    logic [W-1:0]  OUT_PC;
    logic [W-1:0]  OUT_INSTR;
    logic [CW-1:0] COUNT;

    int checks = 0;
    int passes = 0;

    // Model: a queue of {pc, instr} pairs, front = head presented to decode.
    logic [2*W-1:0] model_q[$];

    if_id_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_PC     (IN_PC),
        .IN_INSTR  (IN_INSTR),
        .STALL     (STALL),
        .OUT_VALID (OUT_VALID),
        .OUT_PC    (OUT_PC),
        .OUT_INSTR (OUT_INSTR),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp)
            passes++;
        else
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One transaction: drive after the falling edge, check outputs, then advance the model at the rising edge.
    task automatic cycle(input logic fl, input logic iv, input logic [W-1:0] pc,
                         input logic [W-1:0] ins, input logic rdy);
        int          n;
        logic        byp;
        logic        exp_valid;
        logic [W-1:0] exp_pc;
        logic [W-1:0] exp_ins;
        @(negedge CLK);
        FLUSH = fl; IN_VALID = iv; IN_PC = pc; IN_INSTR = ins; OUT_READY = rdy;
        #1;
        n = model_q.size();
`ifdef IF_ID_BYPASS_EN
        byp = (n == 0) && iv && !fl;
`else
        byp = 1'b0;
`endif
        exp_valid = (n > 0) || byp;
        if (byp) begin
            exp_pc = pc; exp_ins = ins;
        end else if (n > 0) begin
            exp_pc = model_q[0][2*W-1:W]; exp_ins = model_q[0][W-1:0];
        end else begin
            exp_pc = '0; exp_ins = '0;
        end
        $display("cyc fl=%0b iv=%0b pc=%h rdy=%0b | cnt=%0d stall=%0b vld=%0b opc=%h",
                 fl, iv, pc, rdy, COUNT, STALL, OUT_VALID, OUT_PC);
        check("count", 64'(COUNT), 64'(n));
        check("stall", 64'(STALL), 64'(n == DEPTH));
        check("out_valid", 64'(OUT_VALID), 64'(exp_valid));
        check("out_pc", 64'(OUT_PC), 64'(exp_pc));
        check("out_instr", 64'(OUT_INSTR), 64'(exp_ins));
        @(posedge CLK);
        if (fl) begin
            model_q.delete();
        end else if (byp && rdy) begin
            // consumed straight through, nothing stored
        end else begin
            if (rdy && n > 0)
                void'(model_q.pop_front());
            if (iv && n < DEPTH)
                model_q.push_back({pc, ins});
        end
    endtask

    function automatic logic [W-1:0] ins_of(input logic [W-1:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    initial begin
        // Power-on reset
        #2 RST = 1'b1;
        #1;
        check("rst_count", 64'(COUNT), 64'd0);
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_stall", 64'(STALL), 64'd0);
        check("rst_instr", 64'(OUT_INSTR), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Fill to full, third pair refused
        cycle(0, 1, 32'h0, ins_of(32'h0), 0);
        cycle(0, 1, 32'h4, ins_of(32'h4), 0);
        cycle(0, 1, 32'h8, ins_of(32'h8), 0);
        // Drain in order
        cycle(0, 0, 32'h0, 32'h0, 1);
        cycle(0, 0, 32'h0, 32'h0, 1);
        cycle(0, 0, 32'h0, 32'h0, 1);

        // Concurrent push/pop at COUNT=1 across pointer wrap
        cycle(0, 1, 32'h10, ins_of(32'h10), 0);
        for (int k = 1; k <= 5; k++)
            cycle(0, 1, 32'h10 + 32'(4 * k), ins_of(32'h10 + 32'(4 * k)), 1);
        cycle(0, 0, 32'h0, 32'h0, 1);
        cycle(0, 0, 32'h0, 32'h0, 0);

        // Flush while full with push and pop requested
        cycle(0, 1, 32'h30, ins_of(32'h30), 0);
        cycle(0, 1, 32'h34, ins_of(32'h34), 0);
        cycle(1, 1, 32'h38, ins_of(32'h38), 1);
        cycle(1, 1, 32'h3C, ins_of(32'h3C), 0);
        cycle(0, 1, 32'h40, ins_of(32'h40), 0);
        cycle(0, 0, 32'h0, 32'h0, 0);
        cycle(0, 0, 32'h0, 32'h0, 1);

        // Empty with pair offered and decode ready
        cycle(0, 1, 32'h20, ins_of(32'h20), 1);
        cycle(0, 0, 32'h0, 32'h0, 1);
        cycle(0, 0, 32'h0, 32'h0, 1);

        // Asynchronous reset mid-cycle with one entry stored
        cycle(0, 1, 32'h50, ins_of(32'h50), 0);
        @(negedge CLK);
        FLUSH = 0; IN_VALID = 0; OUT_READY = 0;
        #1;
        check("pre_rst_count", 64'(COUNT), 64'd1);
        #1 RST = 1'b1;
        #1;
        check("async_rst_count", 64'(COUNT), 64'd0);
        check("async_rst_valid", 64'(OUT_VALID), 64'd0);
        check("async_rst_stall", 64'(STALL), 64'd0);
        check("async_rst_instr", 64'(OUT_INSTR), 64'd0);
        model_q.delete();
        @(negedge CLK);
        RST = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] rpc;
            rpc = $urandom & 32'hFFFF_FFFC;
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  rpc, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
